// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width: clog2(width), never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/adder1b.sv
// One-bit full-adder cell, reused once per bit position by serial_adder.
module adder1b (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walked LSB-first over WIDTH cycles,
// carry held in a flop, operands/result exchanged through a start/done handshake.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             carry_q;
    logic             msb_cin_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_s;
    logic             cell_cout;

    adder1b u_cell (cell_s, cell_cout, a_sh_q[0], b_sh_q[0], carry_q);

    // Handshake FSM plus the serial datapath it sequences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_sh_q  <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    res_sh_q <= {cell_s, res_sh_q[WIDTH-1:1]};
                    carry_q  <= cell_cout;
                    // The carry entering this last bit is the MSB carry-in for overflow.
                    if (cnt_q == CNT_LAST) begin
                        msb_cin_q <= carry_q;
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = res_sh_q;
    assign bus.cout     = carry_q;
    assign bus.overflow = msb_cin_q ^ carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, scoreboard queue, and hand-built
// sequences for mid-run reset, ignored start and back-to-back operation.
module tb_serial_adder;
    import adder_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;
    int   last_done_cyc = -1;
    int   prev_done_cyc = -1;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder_if #(.WIDTH(W)) sa_if ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(sa_if));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum = full[W-1:0];
        e.cout = full[W];
        e.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        e.acc_cyc = -1;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse pops and checks one expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (sa_if.busy === 1'b1) busy_cnt++;
            if (sa_if.done === 1'b1) begin
                check("done_one_cycle", {63'd0, prev_done}, 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(sb_q.size()), 64'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sum", 64'(sa_if.sum), 64'(mon_e.sum));
                    check("cout", {63'd0, sa_if.cout}, {63'd0, mon_e.cout});
                    check("overflow", {63'd0, sa_if.overflow}, {63'd0, mon_e.ovf});
                    check("busy_cycles", 64'(busy_cnt), 64'(W));
                    if (mon_e.acc_cyc >= 0)
                        check("latency", 64'(cyc - mon_e.acc_cyc), 64'(W));
                end
                busy_cnt = 0;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
            end
            prev_done = sa_if.done;
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input exp_t e);
        exp_t ee;
        @(negedge clk);
        sa_if.start = 1'b1;
        sa_if.a = a;
        sa_if.b = b;
        sa_if.cin = cin;
        @(posedge clk);
        #1;
        ee = e;
        ee.acc_cyc = cyc;
        sb_q.push_back(ee);
        sa_if.start = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            if (sa_if.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, {63'd0, sa_if.busy}, 64'd0);
        check({tag, "_done"}, {63'd0, sa_if.done}, 64'd0);
        check({tag, "_sum"}, 64'(sa_if.sum), 64'd0);
        check({tag, "_cout"}, {63'd0, sa_if.cout}, 64'd0);
        check({tag, "_ovf"}, {63'd0, sa_if.overflow}, 64'd0);
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        sa_if.start = 1'b0;
        sa_if.a = '0;
        sa_if.b = '0;
        sa_if.cin = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // Reset in the middle of RUN: outputs clear and no done is produced.
        @(negedge clk);
        sa_if.start = 1'b1;
        sa_if.a = 32'h0000_FFFF;
        sa_if.b = 32'h0000_0001;
        @(posedge clk);
        #1;
        sa_if.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cleared("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);
        check("idle_after_reset_busy", {63'd0, sa_if.busy}, 64'd0);
        start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, model(32'h0000_FFFF, 32'h0000_0001, 1'b0));
        wait_done();

        foreach (vecs[i]) begin
            e1.sum = vecs[i].sum;
            e1.cout = vecs[i].cout;
            e1.ovf = vecs[i].ovf;
            e1.acc_cyc = -1;
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, e1);
            wait_done();
        end

        // Carry-in only, with a start pulse during RUN that must be ignored.
        e1 = '{32'h0000_0001, 1'b0, 1'b0, -1};
        start_op(32'h0, 32'h0, 1'b1, e1);
        repeat (5) @(negedge clk);
        sa_if.start = 1'b1;
        sa_if.a = 32'h0000_0005;
        sa_if.b = 32'h0000_0006;
        sa_if.cin = 1'b0;
        @(negedge clk);
        sa_if.start = 1'b0;
        wait_done();

        // Back-to-back: start held high through DONE re-accepts immediately.
        e1 = '{32'h2345_6789, 1'b0, 1'b0, -1};
        e2 = '{32'hFFFF_FFFF, 1'b1, 1'b0, -1};
        @(negedge clk);
        sa_if.start = 1'b1;
        sa_if.a = 32'h1234_5678;
        sa_if.b = 32'h1111_1111;
        sa_if.cin = 1'b0;
        @(posedge clk);
        #1;
        e1.acc_cyc = cyc;
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        sa_if.a = 32'hFFFF_FFFF;
        sa_if.b = 32'hFFFF_FFFF;
        sa_if.cin = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        sa_if.start = 1'b0;
        wait_done();
        check("b2b_spacing", 64'(last_done_cyc - prev_done_cyc), 64'(W + 1));

        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            start_op(ra, rb, rc, model(ra, rb, rc));
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
